// File: rtl/ram_multilane.sv
// Multi-lane scratch RAM: NUM_LANES x DATA_WIDTH per word, per-lane write mask, built-in clear engine.
// Read latency 0/1/2 cycles (READ_LATENCY); reads fully pipelined, one per cycle.
// No backpressure; while clear_busy is high all read/write/clear commands are dropped.
module ram_multilane #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_LANES    = 4,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            read_req,
  input  logic [ADDR_WIDTH-1:0]           read_addr,
  output logic [NUM_LANES*DATA_WIDTH-1:0] read_data,
  output logic                            read_valid,
  input  logic                            write_req,
  input  logic [ADDR_WIDTH-1:0]           write_addr,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] write_data,
  input  logic [NUM_LANES-1:0]            write_mask,
  input  logic                            clear_req,
  output logic                            clear_busy
);

  localparam int W     = NUM_LANES * DATA_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (READ_LATENCY < 0 || READ_LATENCY > 2 || NUM_LANES < 1) begin : g_bad_param
    $error("ram_multilane: READ_LATENCY must be 0..2 and NUM_LANES >= 1");
  end

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;

  logic [W-1:0] mem [DEPTH];

  logic         wr_acc;
  logic         rd_acc;
  logic [W-1:0] rd_old;
  logic [W-1:0] rd_word;

  // Commands are only honoured while the clear engine is idle.
  assign wr_acc     = write_req & (state_q == S_IDLE);
  assign rd_acc     = read_req  & (state_q == S_IDLE);
  assign rd_old     = mem[read_addr];
  assign clear_busy = busy_q;

  // Clear engine: walks every word once, busy is registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clear_req) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; clear engine has priority over user writes.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem[cnt_q] <= {NUM_LANES{CLEAR_VALUE}};
    end else if (wr_acc) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (write_mask[i]) begin
          mem[write_addr][i*DATA_WIDTH +: DATA_WIDTH] <= write_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Same-cycle collision: in write-first mode masked lanes forward the incoming write data.
  always_comb begin
    rd_word = rd_old;
    if (WRITE_FIRST != 0 && rd_acc && wr_acc && (read_addr == write_addr)) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (write_mask[i]) begin
          rd_word[i*DATA_WIDTH +: DATA_WIDTH] = write_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  if (READ_LATENCY == 0) begin : g_lat0
    assign read_data  = rd_word;
    assign read_valid = rd_acc;
  end else begin : g_latn
    logic [W-1:0]            dat_q [READ_LATENCY];
    logic [READ_LATENCY-1:0] vld_q;

    // Read pipeline: data stages only advance behind a valid, so the output holds its last value.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_q <= '0;
        for (int s = 0; s < READ_LATENCY; s++) begin
          dat_q[s] <= '0;
        end
      end else begin
        vld_q[0] <= rd_acc;
        if (rd_acc) begin
          dat_q[0] <= rd_word;
        end
        for (int s = 1; s < READ_LATENCY; s++) begin
          vld_q[s] <= vld_q[s-1];
          if (vld_q[s-1]) begin
            dat_q[s] <= dat_q[s-1];
          end
        end
      end
    end

    assign read_data  = dat_q[READ_LATENCY-1];
    assign read_valid = vld_q[READ_LATENCY-1];
  end

endmodule

// File: tb/tb_ram_multilane.sv
// Bench for ram_multilane: three instances (default / latency0 write-old / latency2 write-first).
// Instance A: AW=10, L=1, WF=1. B: AW=4, L=0, WF=0. C: AW=4, L=2, WF=1.
// Shared command inputs, separate resets so one instance can be reset mid-clear.
module tb_ram_multilane;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, rst_c;
  logic        read_req;
  logic [9:0]  read_addr;
  logic        write_req;
  logic [9:0]  write_addr;
  logic [31:0] write_data;
  logic [3:0]  write_mask;
  logic        clear_req;

  logic [31:0] rd_a, rd_b, rd_c;
  logic        vld_a, vld_b, vld_c;
  logic        busy_a, busy_b, busy_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_multilane u_a (
    .clk(clk), .reset(rst_a),
    .read_req(read_req), .read_addr(read_addr), .read_data(rd_a), .read_valid(vld_a),
    .write_req(write_req), .write_addr(write_addr), .write_data(write_data), .write_mask(write_mask),
    .clear_req(clear_req), .clear_busy(busy_a)
  );

  ram_multilane #(.ADDR_WIDTH(4), .READ_LATENCY(0), .WRITE_FIRST(0)) u_b (
    .clk(clk), .reset(rst_b),
    .read_req(read_req), .read_addr(read_addr[3:0]), .read_data(rd_b), .read_valid(vld_b),
    .write_req(write_req), .write_addr(write_addr[3:0]), .write_data(write_data), .write_mask(write_mask),
    .clear_req(clear_req), .clear_busy(busy_b)
  );

  ram_multilane #(.ADDR_WIDTH(4), .READ_LATENCY(2), .WRITE_FIRST(1)) u_c (
    .clk(clk), .reset(rst_c),
    .read_req(read_req), .read_addr(read_addr[3:0]), .read_data(rd_c), .read_valid(vld_c),
    .write_req(write_req), .write_addr(write_addr[3:0]), .write_data(write_data), .write_mask(write_mask),
    .clear_req(clear_req), .clear_busy(busy_c)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    write_req  = 1'b1;
    write_addr = a;
    write_data = d;
    write_mask = m;
    tick();
    write_req  = 1'b0;
  endtask

  // Single read observed on all three instances at their respective latencies.
  task automatic rd_all(input string tag, input logic [9:0] a, input logic [31:0] exp);
    read_req  = 1'b1;
    read_addr = a;
    #1;
    chk({tag, "_b_vld"}, {31'd0, vld_b}, 32'd1);
    chk({tag, "_b"}, rd_b, exp);
    tick();
    read_req = 1'b0;
    chk({tag, "_a_vld"}, {31'd0, vld_a}, 32'd1);
    chk({tag, "_a"}, rd_a, exp);
    chk({tag, "_c_vld_early"}, {31'd0, vld_c}, 32'd0);
    tick();
    chk({tag, "_c_vld"}, {31'd0, vld_c}, 32'd1);
    chk({tag, "_c"}, rd_c, exp);
    chk({tag, "_a_vld_drop"}, {31'd0, vld_a}, 32'd0);
    chk({tag, "_a_hold"}, rd_a, exp);
    chk({tag, "_b_vld_drop"}, {31'd0, vld_b}, 32'd0);
  endtask

  // Back-to-back reads of all 16 words on B (combinational) and C (2-cycle pipeline).
  task automatic sweep(input string tag, input logic [31:0] base, input int nclr);
    logic [31:0] exp;
    logic [31:0] prev;
    prev = '0;
    for (int a = 0; a < 16; a++) begin
      read_req  = 1'b1;
      read_addr = 10'(a);
      #1;
      exp = (a < nclr) ? 32'd0 : base + 32'(a);
      chk({tag, "_b"}, rd_b, exp);
      tick();
      if (a >= 1) begin
        chk({tag, "_c_vld"}, {31'd0, vld_c}, 32'd1);
        chk({tag, "_c"}, rd_c, prev);
      end
      prev = exp;
    end
    read_req = 1'b0;
    tick();
    chk({tag, "_c_vld_last"}, {31'd0, vld_c}, 32'd1);
    chk({tag, "_c_last"}, rd_c, prev);
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      wr(10'(i), base + 32'(i), 4'hF);
    end
  endtask

  initial begin
    int cnt_b;
    int cnt_c;
    bit seen;

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    read_req = 1'b0; read_addr = '0;
    write_req = 1'b0; write_addr = '0; write_data = '0; write_mask = '0;
    clear_req = 1'b0;

    // Reset state
    repeat (3) tick();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick();
    chk("rst_a_data", rd_a, 32'd0);
    chk("rst_a_vld", {31'd0, vld_a}, 32'd0);
    chk("rst_a_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_b_vld", {31'd0, vld_b}, 32'd0);
    chk("rst_b_busy", {31'd0, busy_b}, 32'd0);
    chk("rst_c_data", rd_c, 32'd0);
    chk("rst_c_vld", {31'd0, vld_c}, 32'd0);
    chk("rst_c_busy", {31'd0, busy_c}, 32'd0);

    // Full-word write then read, all latencies
    wr(10'd5, 32'h04030201, 4'hF);
    rd_all("full", 10'd5, 32'h04030201);

    // Partial mask: lanes 0 and 2 replaced
    wr(10'd5, 32'hAABBCCDD, 4'b0101);
    rd_all("mask", 10'd5, 32'h04BB02DD);

    // Mask of zero is a no-op
    wr(10'd5, 32'hFFFFFFFF, 4'b0000);
    rd_all("mask0", 10'd5, 32'h04BB02DD);

    // Same-cycle same-address collision
    wr(10'd7, 32'h11111111, 4'hF);
    write_req  = 1'b1;
    write_addr = 10'd7;
    write_data = 32'h22222222;
    write_mask = 4'b0011;
    read_req   = 1'b1;
    read_addr  = 10'd7;
    #1;
    chk("coll_b_vld", {31'd0, vld_b}, 32'd1);
    chk("coll_b_old", rd_b, 32'h11111111);
    tick();
    write_req = 1'b0;
    read_req  = 1'b0;
    chk("coll_a_new", rd_a, 32'h11112222);
    tick();
    chk("coll_c_new", rd_c, 32'h11112222);
    // Read in the cycle after the write sees new data everywhere
    rd_all("after_wr", 10'd7, 32'h11112222);

    // Clear engine on the 16-word instances; A held in reset so it stays out of the way
    rst_a = 1'b0;
    fill(32'h5A5A5A00);
    clear_req = 1'b1;
    cnt_b = 0;
    cnt_c = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) begin
        clear_req  = 1'b0;
        read_req   = 1'b1;
        read_addr  = 10'd3;
        write_req  = 1'b1;
        write_addr = 10'd3;
        write_data = 32'hDEADBEEF;
        write_mask = 4'hF;
        #1;
      end
      if (busy_b) begin
        cnt_b++;
        chk("clr_b_no_vld", {31'd0, vld_b}, 32'd0);
      end
      if (busy_c) begin
        cnt_c++;
        seen = 1'b1;
        chk("clr_c_no_vld", {31'd0, vld_c}, 32'd0);
      end else if (seen) begin
        read_req  = 1'b0;
        write_req = 1'b0;
      end
    end
    chk("clr_b_busy_cycles", 32'(cnt_b), 32'd16);
    chk("clr_c_busy_cycles", 32'(cnt_c), 32'd16);
    chk("clr_c_vld_after", {31'd0, vld_c}, 32'd0);
    sweep("clr_all", 32'h5A5A5A00, 16);

    // Reset in clear cycle 8: words 0..7 cleared, 8..15 untouched
    fill(32'h600DF000);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (8) tick();
    chk("abort_b_busy_pre", {31'd0, busy_b}, 32'd1);
    rst_b = 1'b0;
    rst_c = 1'b0;
    #1;
    chk("abort_b_busy", {31'd0, busy_b}, 32'd0);
    chk("abort_c_busy", {31'd0, busy_c}, 32'd0);
    tick();
    rst_b = 1'b1;
    rst_c = 1'b1;
    tick();
    chk("abort_c_busy_after", {31'd0, busy_c}, 32'd0);
    sweep("abort", 32'h600DF000, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
